// File: rtl/xadc_temp_filter_if.sv
// -----------------------------------------------------------------------------
// xadc_temp_filter_if
//
// Purpose:
//   Groups the XADC conversion/DRP handshake between the XADC primitive and the
//   temperature filter.
//
// Signals:
//   eoc      XADC end-of-conversion pulse          (XADC -> filter)
//   drpData  DRP read data, result in bits [15:4]  (XADC -> filter)
//   drdy     DRP data-ready pulse                  (XADC -> filter)
//   den      DRP enable, one-cycle pulse           (filter -> XADC)
//   daddr    DRP address                           (filter -> XADC)
//
// Modports:
//   master   the filter side (issues DRP reads)
//   slave    the XADC side
// -----------------------------------------------------------------------------
interface xadc_temp_filter_if;
    logic        eoc;
    logic [15:0] drpData;
    logic        drdy;
    logic        den;
    logic [6:0]  daddr;

    modport master (
        input  eoc,
        input  drpData,
        input  drdy,
        output den,
        output daddr
    );

    modport slave (
        output eoc,
        output drpData,
        output drdy,
        input  den,
        input  daddr
    );
endinterface

// File: rtl/xadc_temp_filter.sv
// -----------------------------------------------------------------------------
// xadc_temp_filter
//
// Purpose:
//   Reads the XADC temperature channel over DRP after every end-of-conversion,
//   averages a window of 2**LOG2_SAMPLES conversions and presents a 12-bit
//   filtered temperature with a level ready flag, so downstream HOT/COLD
//   decisions do not chatter on single-sample noise.
//
// Parameters:
//   CHANNEL_ADDR  DRP address of the temperature channel
//   LOG2_SAMPLES  window size = 2**LOG2_SAMPLES conversions (0..4)
//   TIMEOUT       CLK cycles allowed in WAIT before aborting (watchdog build)
//
// Ports:
//   CLK           system clock
//   RST_N         asynchronous active-low reset
//   drp           XADC handshake (master modport): eoc, drpData, drdy in;
//                 den, daddr out
//   digitalTemp   averaged temperature code, held between updates
//   ready         high once the first full window has been averaged
//   sampleStrobe  one-cycle pulse coincident with each digitalTemp update
//   drpError      sticky DRP timeout flag (0 unless watchdog built)
//
// Build option:
//   XADC_TIMEOUT_EN  when defined, a watchdog aborts a DRP read that gets no
//                    drdy within TIMEOUT cycles, flags drpError and drops the
//                    partial window. When undefined, WAIT blocks indefinitely.
// -----------------------------------------------------------------------------
module xadc_temp_filter #(
    parameter logic [6:0] CHANNEL_ADDR = 7'h13,
    parameter int         LOG2_SAMPLES = 2,
    parameter int         TIMEOUT      = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    xadc_temp_filter_if.master  drp,
    output logic [11:0]         digitalTemp,
    output logic                ready,
    output logic                sampleStrobe,
    output logic                drpError
);

    // Accumulator is wide enough for a full window of 12-bit samples.
    localparam int ACC_W = 12 + LOG2_SAMPLES;
    localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_SAMPLES) - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACC,
        UPDATE
    } state_t;

    state_t             state;
    logic [11:0]        sample;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               den_r;

    // Truncating mean of a full window.
    function automatic logic [11:0] window_mean(input logic [ACC_W-1:0] sum);
        return 12'(sum >> LOG2_SAMPLES);
    endfunction

    assign drp.daddr = CHANNEL_ADDR;
    assign drp.den   = den_r;

    // The low nibble of the DRP word carries no conversion data.
    logic unused_drp_lsbs;
    assign unused_drp_lsbs = &{1'b0, drp.drpData[3:0]};

`ifdef XADC_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd;
    logic            drp_err_r;
    assign drpError = drp_err_r;
`else
    assign drpError = 1'b0;
`endif

    // Captured conversion result; pure data, no reset needed since it is only
    // consumed in ACC after being written in WAIT.
    always_ff @(posedge CLK) begin
        if (state == WAIT && drp.drdy) begin
            sample <= drp.drpData[15:4];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            den_r        <= 1'b0;
            digitalTemp  <= '0;
            ready        <= 1'b0;
            sampleStrobe <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
`ifdef XADC_TIMEOUT_EN
            wd           <= '0;
            drp_err_r    <= 1'b0;
`endif
        end else begin
            // den and sampleStrobe are single-cycle pulses by default.
            den_r        <= 1'b0;
            sampleStrobe <= 1'b0;
            case (state)
                IDLE: begin
                    // eoc wins over a simultaneous drdy; drdy is ignored here.
                    if (drp.eoc) begin
                        state <= REQ;
                        den_r <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
`ifdef XADC_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                WAIT: begin
                    if (drp.drdy) begin
                        state <= ACC;
                    end
`ifdef XADC_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        // Abort: drop the partial window, keep the last output.
                        drp_err_r <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                ACC: begin
                    acc   <= acc + ACC_W'(sample);
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == LAST_CNT) ? UPDATE : IDLE;
                end
                UPDATE: begin
                    // Strobe and ready become visible together with the new value.
                    digitalTemp  <= window_mean(acc);
                    sampleStrobe <= 1'b1;
                    ready        <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_temp_filter.sv
// -----------------------------------------------------------------------------
// tb_xadc_temp_filter
//
// Purpose:
//   Self-checking bench for xadc_temp_filter. Two instances share one XADC
//   stimulus stream: a 4-sample window (LOG2_SAMPLES=2) and a pass-through
//   (LOG2_SAMPLES=0). A reference model keeps the accepted samples in queues
//   and averages each full window arithmetically. When XADC_TIMEOUT_EN is
//   defined the bench also exercises the watchdog abort.
// -----------------------------------------------------------------------------
module tb_xadc_temp_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        eoc;
    logic [15:0] drp_data;
    logic        drdy;

    always #5 clk = ~clk;

    xadc_temp_filter_if if4 ();
    xadc_temp_filter_if if1 ();

    assign if4.eoc     = eoc;
    assign if4.drpData = drp_data;
    assign if4.drdy    = drdy;
    assign if1.eoc     = eoc;
    assign if1.drpData = drp_data;
    assign if1.drdy    = drdy;

    logic [11:0] temp4, temp1;
    logic        rdy4, rdy1, stb4, stb1, err4, err1;

    xadc_temp_filter #(
        .CHANNEL_ADDR (7'h13),
        .LOG2_SAMPLES (2),
        .TIMEOUT      (16)
    ) dut4 (
        .CLK          (clk),
        .RST_N        (rst_n),
        .drp          (if4),
        .digitalTemp  (temp4),
        .ready        (rdy4),
        .sampleStrobe (stb4),
        .drpError     (err4)
    );

    xadc_temp_filter #(
        .CHANNEL_ADDR (7'h13),
        .LOG2_SAMPLES (0),
        .TIMEOUT      (16)
    ) dut1 (
        .CLK          (clk),
        .RST_N        (rst_n),
        .drp          (if1),
        .digitalTemp  (temp1),
        .ready        (rdy1),
        .sampleStrobe (stb1),
        .drpError     (err1)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          q4[$];
    int          q1[$];
    int          exp_t4 = 0, exp_t1 = 0;
    bit          exp_r4 = 0, exp_r1 = 0;
    bit          exp_err = 0;
    int          exp_den = 0, exp_stb4 = 0, exp_stb1 = 0;

    int          den_cnt = 0, stb_cnt4 = 0, stb_cnt1 = 0;
    bit          daddr_bad = 0;

    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse/constant monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (if4.den) den_cnt <= den_cnt + 1;
        if (stb4)    stb_cnt4 <= stb_cnt4 + 1;
        if (stb1)    stb_cnt1 <= stb_cnt1 + 1;
        if (if4.daddr !== 7'h13 || if1.daddr !== 7'h13) daddr_bad <= 1'b1;
    end

    // Mean of a window, straight from the averaging rule.
    function automatic int mean_of(input int q[$]);
        int sum = 0;
        foreach (q[i]) sum += q[i];
        return sum / q.size();
    endfunction

    // One XADC conversion: eoc, expect den, answer with drdy after `delay`
    // cycles. Starts and ends on a negedge with both DUTs idle.
    task automatic conv(input int s, input int delay, input bit noise_eoc, input bit idle_drdy);
        bit upd4;
        bit upd1;
        int m4;
        int m1;
        eoc = 1'b1;
        if (idle_drdy) begin
            drdy     = 1'b1;
            drp_data = 16'hFFF0;
        end
        @(negedge clk);
        eoc  = 1'b0;
        drdy = 1'b0;
        check("den_req4", if4.den, 1);
        check("den_req1", if1.den, 1);
        exp_den++;
        @(negedge clk);
        check("den_once", if4.den, 0);
        for (int i = 0; i < delay; i++) begin
            eoc = noise_eoc ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        eoc      = 1'b0;
        drdy     = 1'b1;
        drp_data = {12'(s), 4'($urandom_range(0, 15))};
        @(negedge clk);
        drdy     = 1'b0;
        drp_data = 16'($urandom);
        q4.push_back(s);
        q1.push_back(s);
        upd4 = (q4.size() == 4);
        upd1 = (q1.size() == 1);
        m4 = upd4 ? mean_of(q4) : exp_t4;
        m1 = upd1 ? mean_of(q1) : exp_t1;
        if (upd4) q4.delete();
        if (upd1) q1.delete();
        @(negedge clk);
        // One cycle after drdy's ACC cycle the output must not have moved yet.
        check("hold_t4", temp4, exp_t4);
        check("hold_stb4", stb4, 0);
        @(negedge clk);
        if (upd4) begin exp_t4 = m4; exp_r4 = 1; exp_stb4++; end
        if (upd1) begin exp_t1 = m1; exp_r1 = 1; exp_stb1++; end
        check("temp4", temp4, exp_t4);
        check("ready4", rdy4, exp_r4);
        check("stb4", stb4, upd4);
        check("temp1", temp1, exp_t1);
        check("ready1", rdy1, exp_r1);
        check("stb1", stb1, upd1);
        check("err4", err4, exp_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_temp4", temp4, 0);
        check("rst_ready4", rdy4, 0);
        check("rst_ready1", rdy1, 0);
        check("rst_stb4", stb4, 0);
        check("rst_den4", if4.den, 0);
        check("rst_err4", err4, 0);
        q4.delete();
        q1.delete();
        exp_t4 = 0; exp_t1 = 0; exp_r4 = 0; exp_r1 = 0; exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef XADC_TIMEOUT_EN
    task automatic timeout_case();
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        check("to_den", if4.den, 1);
        exp_den++;
        repeat (16) @(negedge clk);
        check("to_err_early", err4, exp_err);
        @(negedge clk);
        exp_err = 1;
        q4.delete();
        q1.delete();
        check("to_err4", err4, 1);
        check("to_err1", err1, 1);
        check("to_temp4", temp4, exp_t4);
        check("to_ready4", rdy4, exp_r4);
        check("to_temp1", temp1, exp_t1);
        @(negedge clk);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n    = 1'b0;
        eoc      = 1'b0;
        drdy     = 1'b0;
        drp_data = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_temp4", temp4, 0);
        check("reset_ready4", rdy4, 0);
        check("reset_stb4", stb4, 0);
        check("reset_den4", if4.den, 0);
        check("reset_err4", err4, 0);
        check("reset_daddr", if4.daddr, 7'h13);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant window of 1200.
        for (int i = 0; i < 4; i++) conv(1200, 2, 0, 0);
        // Truncating average: 4803 >> 2 = 1200.
        conv(1196, 1, 0, 0);
        conv(1200, 0, 0, 0);
        conv(1204, 3, 0, 0);
        conv(1203, 1, 0, 0);
        // Extra eoc during WAIT and drdy alongside eoc in IDLE are ignored.
        for (int i = 0; i < 4; i++) conv(2000 + i * 7, 4, 1, i[0]);

        // Reset mid-window, then a fresh window of 1900.
        conv(300, 1, 0, 0);
        conv(310, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) conv(1900, 1, 0, 0);

        // Pass-through instance sees 1000 then 2000.
        conv(1000, 0, 0, 0);
        conv(2000, 0, 0, 0);

`ifdef XADC_TIMEOUT_EN
        conv(700, 1, 0, 0);
        timeout_case();
        for (int i = 0; i < 4; i++) conv(800 + i, 2, 0, 0);
`else
        // Without the watchdog a slow drdy is simply waited for.
        conv(555, 40, 0, 0);
        check("no_err", err4, 0);
`endif

        // Randomized conversions.
        for (int i = 0; i < 40; i++) begin
            conv(int'($urandom_range(0, 4095)), int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check("den_count", den_cnt, exp_den);
        check("stb_count4", stb_cnt4, exp_stb4);
        check("stb_count1", stb_cnt1, exp_stb1);
        check("daddr_const", daddr_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_temp_filter.md
Name: xadc_temp_filter

Overview:
- Upstream neighbour of the material system: owns the XADC DRP read of the station temperature channel.
- Averages a window of conversions and presents a 12-bit filtered temperature (digitalTemp) plus a level ready flag, so station HOT/COLD/ambient decisions do not chatter on single-sample noise.
- Sits between the XADC primitive and the material system; one clock domain (CLK).

Parameters:
- CHANNEL_ADDR, 7'h13, DRP address of the temperature channel (VAUX3 status register).
- LOG2_SAMPLES, 2, window size = 2**LOG2_SAMPLES conversions; legal range 0..4.
- TIMEOUT, 16, CLK cycles allowed from den to drdy before abort (used only with the optional feature).

Ports:
- CLK, input, 1, system clock.
- RST_N, input, 1, asynchronous active-low reset.
- eoc, input, 1, XADC end-of-conversion pulse.
- drpData, input, 16, XADC DRP data out; result is in bits [15:4].
- drdy, input, 1, XADC DRP data-ready pulse.
- den, output, 1, DRP enable, one-cycle pulse.
- daddr, output, 7, DRP address; constant CHANNEL_ADDR.
- digitalTemp, output, 12, averaged temperature code.
- ready, output, 1, level; high once the first full window has been averaged.
- sampleStrobe, output, 1, one-cycle pulse whenever digitalTemp updates.
- drpError, output, 1, sticky timeout flag (only with the optional feature, else tied 0).

Behaviour:
- Reset (RST_N low, async): state=IDLE, den=0, digitalTemp=0, ready=0, sampleStrobe=0, drpError=0, accumulator=0, sample count=0. daddr is always CHANNEL_ADDR.
- Accumulator width is 12+LOG2_SAMPLES bits, so it never overflows. Count width is max(LOG2_SAMPLES,1).
- IDLE: wait for eoc=1, then go to REQ. An eoc arriving in any other state is ignored (dropped, not queued).
- REQ: den=1 for exactly this one cycle, then go to WAIT.
- WAIT: hold until drdy=1. On drdy, capture drpData[15:4] and go to ACC.
- ACC: accumulator += captured sample; count += 1.
  - If count was 2**LOG2_SAMPLES-1, go to UPDATE.
  - Otherwise go to IDLE.
- UPDATE:
  - digitalTemp <= accumulator >> LOG2_SAMPLES (truncating).
  - sampleStrobe=1 for this cycle; ready <= 1.
  - Accumulator and count clear; go to IDLE.
- Latency: the last sample's drdy leads the digitalTemp update by 2 cycles (ACC, UPDATE).
- With LOG2_SAMPLES=0 every conversion passes straight through: digitalTemp = the sample.
- ready never deasserts except on reset. digitalTemp holds between updates, so a consumer may sample it any cycle ready=1.
- drdy outside WAIT is ignored.
- Reset mid-window discards the partial accumulator. The next window starts fresh and ready stays 0 until it completes.
- Simultaneous eoc and drdy in IDLE: eoc is taken, drdy is ignored.

Optional Feature:
- Macro: XADC_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT.
  - If TIMEOUT cycles elapse with no drdy, the block sets drpError (sticky until reset), discards the current window (accumulator/count cleared) and returns to IDLE.
  - digitalTemp and ready keep their previous values.
- Not defined:
  - WAIT blocks indefinitely for drdy.
  - drpError is constant 0 and no watchdog logic is built.

Test Plan:
- Reset, then 4 eoc/drdy cycles with drpData=16'h4B00 (sample 1200): ready rises with digitalTemp=1200, sampleStrobe high exactly 1 cycle, den pulses exactly 4 times, daddr=7'h13 throughout.
- Samples 1196, 1200, 1204, 1203: digitalTemp=1200 (4803>>2 truncates), update exactly 2 cycles after the 4th drdy.
- Extra eoc pulses asserted during WAIT: no extra den, and the window still completes after 4 accepted samples.
- RST_N pulled low after 2 samples, then 4 samples of 1900: ready low until the window completes, then digitalTemp=1900 with no contamination from pre-reset data.
- LOG2_SAMPLES=0, samples 1000 then 2000: digitalTemp=1000 then 2000, one sampleStrobe per sample.
- XADC_TIMEOUT_EN defined, TIMEOUT=16, drdy withheld after den: drpError=1 at cycle 16, state returns to IDLE, prior digitalTemp/ready unchanged; the next full window updates normally while drpError stays 1.
